uart: RTL and testbench
=======================

// Module: uart
// PURPOSE
//  8N1 UART block with an independent transmitter and receiver sharing one clock.
//  TX serialises txin on tx when start is requested; RX deserialises rx into rxout.
//  TX and RX have no internal connection. They are normally looped back (tx->rx)
//  at the top level for self-test, and serve as the serial link endpoint.
// PARAMETERS
//  CLK_FREQ   1_000_000  input clock frequency, Hz
//  BAUD_RATE  9600       serial bit rate, bits/s
//  CLKS_PER_BIT (localparam) = CLK_FREQ/BAUD_RATE (integer division; 104 at defaults), >=4
// PORTS
//  clk     in   1  system clock, all logic on rising edge
//  rst_n   in   1  asynchronous active-low reset
//  start   in   1  level request to transmit txin
//  txin    in   8  byte to transmit, captured when a frame is accepted
//  tx      out  1  serial output, idle high
//  rx      in   1  serial input, idle high, asynchronous to clk
//  rxout   out  8  last correctly framed received byte
//  rxdone  out  1  received-byte-valid flag (sticky)
//  txdone  out  1  transmit-complete flag (sticky)
// BEHAVIOUR
//  Interface: one clock (clk); reset rst_n is asynchronous, active-low.
//  Reset values: tx=1, txdone=0, rxdone=0, rxout=8'h00; both FSMs go to IDLE, counters cleared.
//  Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit lasts CLKS_PER_BIT clocks.
//  TX FSM: IDLE -> START -> DATA -> STOP -> DONE.
//   IDLE: tx=1. If start=1, capture txin into shift reg, clear txdone, go to START.
//   START: tx=0 for CLKS_PER_BIT cycles. DATA: drive bits 0..7, CLKS_PER_BIT each.
//   STOP: tx=1 for CLKS_PER_BIT cycles, then set txdone=1 and go to DONE.
//   DONE: tx=1, txdone held 1 while start=1. When start=0, go to IDLE; txdone stays 1
//   until the next frame is accepted.
//   Held start never retriggers: a new frame needs start to drop, then rise again.
//   txin changes during a frame have no effect.
//  TX latency: txdone rises 10*CLKS_PER_BIT (+1) clocks after start is accepted.
//  RX: rx passes through a 2-flop synchroniser; all decisions use the synced value.
//   IDLE: wait for synced rx=0. START: count CLKS_PER_BIT/2; if rx still 0, go to DATA,
//   else return to IDLE (glitch reject).
//   DATA: sample each bit at its centre (every CLKS_PER_BIT), shift in LSB first.
//   STOP: sample at stop-bit centre. If rx=1: rxout<=byte, rxdone<=1, go to IDLE.
//   If rx=0: framing error, discard byte, rxout/rxdone unchanged, go to IDLE.
//  rxdone clears when the next start bit is validated (mid-start-bit), else stays 1.
//  rxout holds its value until the next good frame.
//  In loopback, rxdone rises about half a bit before txdone, so both are high together
//  from txdone rising until the next frame.
//  Reset mid-frame aborts both FSMs immediately: tx=1 and all reset values apply.
// TESTING
//  1 Loopback tx->rx; send 8'h24, 8'h81, 8'h09, 8'h63, 8'h0D. For each, start=1, wait for
//    txdone&&rxdone, start=0, idle 100ns -> rxout equals each byte, in order.
//  2 Bit-level check, txin=8'hA5: tx low 1 bit, then 1,0,1,0,0,1,0,1, then high 1 bit;
//    each bit CLKS_PER_BIT clocks; txdone rises 10*CLKS_PER_BIT(+1) clocks after start.
//  3 Boundary data 8'h00 and 8'hFF in loopback -> rxout=00 then FF, no framing error.
//  4 Hold start=1 for 3 frame times after txdone -> exactly one frame; tx stays 1, txdone stays 1.
//  5 rx low pulse shorter than CLKS_PER_BIT/2 -> no reception; rxdone, rxout unchanged.
//    Frame with stop bit 0 -> discarded.
//  6 Assert rst_n=0 mid DATA -> tx=1, txdone=0, rxdone=0, rxout=00 at once;
//    next frame after release is correct.

Source files
------------

// File: rtl/uart.sv
// 8N1 UART: independent transmitter and receiver on one clock, each a two-process FSM.
// Every bit lasts CLK_FREQ/BAUD_RATE clocks. The receiver samples near each bit centre.
module uart #(
  parameter int CLK_FREQ  = 1_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] txin,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rxout,
  output logic       rxdone,
  output logic       txdone
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t      tx_state, tx_state_n;
  logic [CW-1:0]  tx_cnt, tx_cnt_n;
  logic [2:0]     tx_bit, tx_bit_n;
  logic [7:0]     tx_shreg, tx_shreg_n;
  logic           tx_n, txdone_n;

  rx_state_t      rx_state, rx_state_n;
  logic [CW-1:0]  rx_cnt, rx_cnt_n;
  logic [2:0]     rx_bit, rx_bit_n;
  logic [7:0]     rx_shreg, rx_shreg_n;
  logic [7:0]     rxout_n;
  logic           rxdone_n;
  logic           rx_meta, rx_sync;

  // Transmitter state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shreg <= 8'h00;
      tx       <= 1'b1;
      txdone   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shreg <= tx_shreg_n;
      tx       <= tx_n;
      txdone   <= txdone_n;
    end
  end

  // Transmitter next state; tx is computed one cycle ahead so the pin comes straight from a flop.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shreg_n = tx_shreg;
    tx_n       = tx;
    txdone_n   = txdone;
    case (tx_state)
      TX_IDLE: begin
        if (start) begin
          tx_shreg_n = txin;
          txdone_n   = 1'b0;
          tx_n       = 1'b0;
          tx_cnt_n   = '0;
          tx_state_n = TX_START;
        end else begin
          tx_n = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt == LAST_CNT) begin
          tx_cnt_n   = '0;
          tx_bit_n   = 3'd0;
          tx_n       = tx_shreg[0];
          tx_state_n = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt == LAST_CNT) begin
          tx_cnt_n   = '0;
          tx_shreg_n = {1'b0, tx_shreg[7:1]};
          if (tx_bit == 3'd7) begin
            tx_n       = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_n     = tx_shreg[1];
            tx_bit_n = tx_bit + 3'd1;
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == LAST_CNT) begin
          tx_cnt_n   = '0;
          txdone_n   = 1'b1;
          tx_state_n = TX_DONE;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_DONE: begin
        tx_n = 1'b1;
        if (!start) begin
          tx_state_n = TX_IDLE;
        end else begin
          tx_state_n = TX_DONE;
        end
      end
      default: begin
        tx_n       = 1'b1;
        tx_state_n = TX_IDLE;
      end
    endcase
  end

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shreg <= 8'h00;
      rxout    <= 8'h00;
      rxdone   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shreg <= rx_shreg_n;
      rxout    <= rxout_n;
      rxdone   <= rxdone_n;
    end
  end

  // Receiver next state: half-bit start validation, then one sample per bit period.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shreg_n = rx_shreg;
    rxout_n    = rxout;
    rxdone_n   = rxdone;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_START;
        end else begin
          rx_cnt_n = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_CNT) begin
          rx_cnt_n = '0;
          if (!rx_sync) begin
            rx_bit_n   = 3'd0;
            rxdone_n   = 1'b0;
            rx_state_n = RX_DATA;
          end else begin
            rx_state_n = RX_IDLE;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == LAST_CNT) begin
          rx_cnt_n   = '0;
          rx_shreg_n = {rx_sync, rx_shreg[7:1]};
          if (rx_bit == 3'd7) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_bit_n = rx_bit + 3'd1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == LAST_CNT) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          if (rx_sync) begin
            rxout_n  = rx_shreg;
            rxdone_n = 1'b1;
          end else begin
            rxout_n = rxout;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      default: begin
        rx_state_n = RX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: table-driven loopback bytes, random bytes against a frame model,
// and hand-written sequences for glitch/framing rejection, held start and mid-frame reset.
module tb_uart;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int C = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] txin = 8'h00;
  logic       tx;
  logic       rx_line;
  logic [7:0] rxout;
  logic       rxdone;
  logic       txdone;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs[7];

  assign rx_line = loop_en ? tx : rx_drv;

  uart #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .txin(txin), .tx(tx),
    .rx(rx_line), .rxout(rxout), .rxdone(rxdone), .txdone(txdone)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Sends one byte in loopback; checks each bit centre against the ideal 8N1 frame,
  // the txdone latency and the received byte. Optionally holds start for 3 frame times.
  task automatic frame(input logic [7:0] b, input logic [7:0] exp_rx, input bit hold);
    logic [9:0] ideal;
    int lat;
    int j;
    bit done;
    bit bad;
    ideal = {1'b1, b, 1'b0};
    lat = -1;
    done = 1'b0;
    @(negedge clk);
    txin  = b;
    start = 1'b1;
    for (j = 0; j < 12 * C && !done; j++) begin
      @(negedge clk);
      if (j == 3 * C) txin = ~b;
      if (j < 10 * C && (j % C) == C / 2)
        check($sformatf("tx_bit%0d_%02h", j / C, b), {31'd0, tx}, {31'd0, ideal[j / C]});
      if (lat < 0 && txdone === 1'b1) lat = j;
      if (txdone === 1'b1 && rxdone === 1'b1) done = 1'b1;
    end
    check("frame_completed", {31'd0, done}, 32'd1);
    check($sformatf("txdone_latency_%0d", lat), {31'd0, (lat == 10 * C || lat == 10 * C + 1)}, 32'd1);
    check($sformatf("rxout_%02h", b), {24'd0, rxout}, {24'd0, exp_rx});
    if (hold) begin
      bad = 1'b0;
      repeat (30 * C) begin
        @(negedge clk);
        if (tx !== 1'b1 || txdone !== 1'b1 || rxdone !== 1'b1) bad = 1'b1;
      end
      check("held_start_no_retrigger", {31'd0, bad}, 32'd0);
    end
    start = 1'b0;
    repeat (2 * C) @(negedge clk);
    check("tx_idle_high", {31'd0, tx}, 32'd1);
  endtask

  // Drives a raw frame onto rx with the given stop-bit value.
  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (C) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (3 * C) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    vecs[0] = '{8'h24, 8'h24};
    vecs[1] = '{8'h81, 8'h81};
    vecs[2] = '{8'h09, 8'h09};
    vecs[3] = '{8'h63, 8'h63};
    vecs[4] = '{8'h0D, 8'h0D};
    vecs[5] = '{8'h00, 8'h00};
    vecs[6] = '{8'hFF, 8'hFF};

    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_txdone", {31'd0, txdone}, 32'd0);
    check("reset_rxdone", {31'd0, rxdone}, 32'd0);
    check("reset_rxout", {24'd0, rxout}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) frame(vecs[i].data, vecs[i].exp_rx, 1'b0);
    last_good = 8'hFF;

    frame(8'hA5, 8'hA5, 1'b1);
    last_good = 8'hA5;

    // Random bytes: the model's expected byte is simply the byte sent over the ideal link.
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      frame(b, b, 1'b0);
      last_good = b;
    end

    // Short low glitch must not start a reception.
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (C) @(negedge clk);
    rx_drv = 1'b0;
    repeat (C / 2 - 2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * C) @(negedge clk);
    check("glitch_rxdone_kept", {31'd0, rxdone}, 32'd1);
    check("glitch_rxout_kept", {24'd0, rxout}, {24'd0, last_good});

    // Stop bit 0: byte discarded; rxdone was already cleared when the start bit validated.
    drive_rx_frame(8'h5A, 1'b0);
    check("framing_err_rxout_kept", {24'd0, rxout}, {24'd0, last_good});
    check("framing_err_rxdone_low", {31'd0, rxdone}, 32'd0);
    loop_en = 1'b1;
    repeat (C) @(negedge clk);
    frame(8'h3C, 8'h3C, 1'b0);

    // Reset in the middle of the data bits.
    @(negedge clk);
    txin  = 8'h96;
    start = 1'b1;
    repeat (4 * C) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_txdone", {31'd0, txdone}, 32'd0);
    check("midreset_rxdone", {31'd0, rxdone}, 32'd0);
    check("midreset_rxout", {24'd0, rxout}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * C) @(negedge clk);
    frame(8'h96, 8'h96, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
